// File: rtl/dac_playback_pkg.sv
// Shared encodings and helpers for the DAC BRAM playback block.
package dac_playback_pkg;

  localparam logic [1:0] MODE_LOOP    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_NLOOP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/dac_bram_playback_if.sv
// AXI-Stream channel carrying playback words towards the DAC.
interface dac_bram_playback_if #(
  parameter int DWIDTH = 64
);
  logic [DWIDTH-1:0] axis_tdata;
  logic              axis_tvalid;
  logic              axis_tready;

  modport master (output axis_tdata, output axis_tvalid, input axis_tready);
  modport slave  (input axis_tdata, input axis_tvalid, output axis_tready);
endinterface

// File: rtl/dac_bram_playback_fifo.sv
// Synchronous output FIFO; flush empties it in one cycle, storage is not reset.
module playback_fifo #(
  parameter int DWIDTH     = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DWIDTH-1:0]             din,
  output logic [DWIDTH-1:0]             dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push)
        wr_q <= wr_q + (AW+1)'(1);
      if (pop && !empty)
        rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= din;
  end

  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/dac_bram_playback.sv
// Plays a BRAM word window out as AXI-Stream with back-pressure; reads are
// credit-limited so every issued read always has a FIFO slot when it returns.
module dac_bram_playback
  import dac_playback_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int LOOP_W     = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  output logic                  portA_clk,
  output logic                  portA_rst,
  output logic                  portA_en,
  output logic [31:0]           portAcpu_addr,
  output logic [DWIDTH/8-1:0]   portA_we,
  output logic [DWIDTH-1:0]     portA_cpu_wdata,
  input  logic [DWIDTH-1:0]     portA_cpu_rdata,
  dac_bram_playback_if.master   axis,
  input  logic [31:0]           start_addr,
  input  logic [31:0]           end_addr,
  input  logic [1:0]            mode,
  input  logic [LOOP_W-1:0]     loop_count,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);
  localparam int unsigned BPW   = bytes_per_word(DWIDTH);
  localparam logic [31:0] STEP  = 32'(BPW);
  localparam int          CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int          OCC_W = CNT_W + 1;

  state_e                state_q, state_d;
  logic [31:0]           start_q, start_d, end_q, end_d, ptr_q, ptr_d;
  logic [1:0]            mode_q, mode_d;
  logic [LOOP_W-1:0]     pass_q, pass_d;
  logic                  abort_q, abort_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [RD_LATENCY-1:0] vld_sr_q;

  logic                  issue, flush, push, pop, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [OCC_W-1:0]      inflight, occ;
  logic                  credit_ok, cfg_ok;
  logic [31:0]           iss_addr, win_start, win_end;
  logic [1:0]            win_mode;
  logic [LOOP_W-1:0]     win_pass;
  logic [DWIDTH-1:0]     fifo_dout;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + OCC_W'(vld_sr_q[i]);
    occ       = OCC_W'(fifo_count) + inflight;
    credit_ok = occ < OCC_W'(FIFO_DEPTH);
  end

  assign cfg_ok = (end_addr >= start_addr) &&
                  ((start_addr % STEP) == 32'd0) &&
                  ((end_addr % STEP) == 32'd0);

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    mode_d    = mode_q;
    pass_d    = pass_q;
    ptr_d     = ptr_q;
    abort_d   = abort_q;
    cfg_err_d = cfg_err_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    flush     = 1'b0;
    win_start = start_q;
    win_end   = end_q;
    win_mode  = mode_q;
    win_pass  = pass_q;
    iss_addr  = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            // The first read goes out in the acceptance cycle itself.
            win_start = start_addr;
            win_end   = end_addr;
            win_mode  = mode;
            win_pass  = (loop_count == '0) ? LOOP_W'(1) : loop_count;
            start_d   = start_addr;
            end_d     = end_addr;
            mode_d    = mode;
            pass_d    = win_pass;
            iss_addr  = start_addr;
            issue     = 1'b1;
            abort_d   = 1'b0;
            cfg_err_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          flush   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stop) begin
          flush   = 1'b1;
          abort_d = 1'b1;
        end
        if (inflight == '0 && (fifo_empty || stop)) begin
          state_d = ST_IDLE;
          done_d  = !stop && !abort_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      ptr_d = iss_addr + STEP;
      if (iss_addr == win_end) begin
        ptr_d = win_start;
        if (win_mode == MODE_NLOOP && win_pass > LOOP_W'(1))
          pass_d = win_pass - LOOP_W'(1);
        else if (win_mode != MODE_LOOP)
          state_d = ST_DRAIN;
      end
    end
  end

  // Returns of reads issued before an abort are dropped on arrival.
  assign push = vld_sr_q[RD_LATENCY-1] && !abort_q && !flush;
  assign pop  = axis.axis_tvalid && axis.axis_tready;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= ST_IDLE;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      vld_sr_q  <= '0;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      vld_sr_q[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++)
        vld_sr_q[i] <= vld_sr_q[i-1];
    end
  end

  always_ff @(posedge axis_clk) begin
    start_q <= start_d;
    end_q   <= end_d;
    mode_q  <= mode_d;
    pass_q  <= pass_d;
    ptr_q   <= ptr_d;
  end

  playback_fifo #(
    .DWIDTH     (DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (portA_cpu_rdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign portA_clk        = axis_clk;
  assign portA_rst        = axis_rst;
  assign portA_en         = issue;
  assign portAcpu_addr    = issue ? iss_addr : 32'd0;
  assign portA_we         = '0;
  assign portA_cpu_wdata  = '0;
  assign axis.axis_tvalid = !fifo_empty;
  assign axis.axis_tdata  = fifo_empty ? '0 : fifo_dout;
  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_dac_bram_playback.sv
// Directed bench for dac_bram_playback: BRAM model, beat scoreboard and
// handshake-hold monitor, plus literal checks on latency, done and errors.
module tb_dac_bram_playback;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam int FD = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          portA_clk, portA_rst, portA_en;
  logic [31:0]   portAcpu_addr;
  logic [DW/8-1:0] portA_we;
  logic [DW-1:0] portA_cpu_wdata, portA_cpu_rdata;
  logic [31:0]   start_addr, end_addr;
  logic [1:0]    mode;
  logic [LW-1:0] loop_count;
  logic          start, stop, busy, done, cfg_err;

  dac_bram_playback_if #(.DWIDTH(DW)) axis ();

  dac_bram_playback #(
    .DWIDTH(DW), .RD_LATENCY(RL), .FIFO_DEPTH(FD), .LOOP_W(LW)
  ) dut (
    .axis_clk(clk), .axis_rst(rst),
    .portA_clk(portA_clk), .portA_rst(portA_rst), .portA_en(portA_en),
    .portAcpu_addr(portAcpu_addr), .portA_we(portA_we),
    .portA_cpu_wdata(portA_cpu_wdata), .portA_cpu_rdata(portA_cpu_rdata),
    .axis(axis.master),
    .start_addr(start_addr), .end_addr(end_addr), .mode(mode),
    .loop_count(loop_count), .start(start), .stop(stop),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: word n holds n, returned RL cycles after the read.
  logic [DW-1:0] bram_pipe [RL];
  always @(posedge clk) begin
    bram_pipe[0] <= portA_en ? DW'(portAcpu_addr >> 3) : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign portA_cpu_rdata = bram_pipe[RL-1];

  int checks = 0, passes = 0, fails = 0;
  logic [63:0] exp_q [$];
  int beats = 0, done_cnt = 0, last_hs_cyc = 0;
  int iss_cnt = 0, hs_cnt = 0, max_out = 0;
  logic stab_skip = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end else begin
      passes++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat list straight from window, mode and pass count.
  function automatic void build_exp(input logic [31:0] s, input logic [31:0] e,
                                    input logic [1:0] m, input int lc);
    int words, npass;
    exp_q.delete();
    words = int'((e - s) >> 3) + 1;
    npass = (m == 2'd0) ? 64 : (m == 2'd2) ? ((lc == 0) ? 1 : lc) : 1;
    for (int p = 0; p < npass; p++)
      for (int w = 0; w < words; w++)
        exp_q.push_back(64'((s >> 3) + 32'(w)));
  endfunction

  task automatic start_pb(input logic [31:0] s, input logic [31:0] e,
                          input logic [1:0] m, input int lc);
    start_addr = s; end_addr = e; mode = m; loop_count = LW'(lc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input logic [15:0] pat, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < maxc; i++) begin
      axis.axis_tready = pat[i % 16];
      tick();
      if (done) begin
        dcyc = cyc;
        check("done_busy_low", busy, 0);
        break;
      end
    end
    axis.axis_tready = 1'b1;
    if (dcyc < 0) begin
      checks++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles", maxc);
    end
  endtask

  task automatic do_stop();
    int nb;
    stab_skip = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_q.delete();
    check("stop_tvalid_low", axis.axis_tvalid, 0);
    nb = 0;
    while (busy && nb < RL + 4) begin
      tick();
      nb++;
    end
    check("stop_busy_fall", (nb <= RL + 1), 1);
    stab_skip = 1'b0;
  endtask

  // Compare process: beats against the model, hold rule, outstanding reads.
  initial begin
    logic [63:0] ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall_prev && !stab_skip) begin
          check("hold_tvalid", axis.axis_tvalid, 1);
          check("hold_tdata", axis.axis_tdata, stall_data);
        end
        if (axis.axis_tvalid && axis.axis_tready) begin
          beats++;
          hs_cnt++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_beat: got %0h with no beat expected (cycle %0d)",
                     axis.axis_tdata, cyc);
          end else begin
            ev = exp_q.pop_front();
            check("beat", axis.axis_tdata, ev);
          end
        end
        if (portA_en) iss_cnt++;
        if (iss_cnt - hs_cnt > max_out) max_out = iss_cnt - hs_cnt;
        if (done) done_cnt++;
      end
      stall_prev = !rst && axis.axis_tvalid && !axis.axis_tready;
      stall_data = axis.axis_tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, b0, d0, dc;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    start_addr = '0; end_addr = '0; mode = '0; loop_count = '0;
    axis.axis_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", axis.axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_en", portA_en, 0);
    check("rst_addr", portAcpu_addr, 0);
    check("portA_rst", portA_rst, 1);
    check("portA_clk", portA_clk, 1);
    check("portA_we", portA_we, 0);
    check("portA_wdata", portA_cpu_wdata, 0);
    rst = 1'b0;
    tick();

    // Loop mode: latency, continuity, value sequence, then stop.
    build_exp(32'h00, 32'h18, 2'd0, 0);
    check("model_loop_4", exp_q[4], 0);
    start_addr = 32'h00; end_addr = 32'h18; mode = 2'd0; loop_count = '0;
    start = 1'b1;
    #1;
    check("first_read_en", portA_en, 1);
    check("first_read_addr", portAcpu_addr, 32'h00);
    tick();
    start = 1'b0;
    n = 1;
    while (!axis.axis_tvalid && n < 20) begin
      tick();
      n++;
    end
    check("first_tvalid_latency", n, RL + 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (axis.axis_tvalid) cnt++;
      tick();
    end
    check("loop_tvalid_continuous", cnt, 12);
    d0 = done_cnt;
    do_stop();
    check("loop_stop_no_done", done_cnt - d0, 0);

    // Replay after stop, stopped five cycles into playback.
    build_exp(32'h00, 32'h18, 2'd0, 0);
    b0 = beats; d0 = done_cnt;
    start_pb(32'h00, 32'h18, 2'd0, 0);
    repeat (4) tick();
    do_stop();
    check("replay_beats", beats - b0, 3);
    check("replay_no_done", done_cnt - d0, 0);

    // One-shot, words 8..11.
    build_exp(32'h40, 32'h58, 2'd1, 0);
    check("model_oneshot_len", exp_q.size(), 4);
    check("model_oneshot_first", exp_q[0], 8);
    check("model_oneshot_last", exp_q[3], 11);
    b0 = beats; d0 = done_cnt;
    start_pb(32'h40, 32'h58, 2'd1, 0);
    wait_done(40, 16'hFFFF, dc);
    check("oneshot_done_after_last", (dc > last_hs_cyc), 1);
    repeat (3) tick();
    check("oneshot_beats", beats - b0, 4);
    check("oneshot_done_once", done_cnt - d0, 1);
    check("oneshot_queue_empty", exp_q.size(), 0);

    // N-loop with back-pressure.
    build_exp(32'h80, 32'h88, 2'd2, 3);
    check("model_nloop_len", exp_q.size(), 6);
    b0 = beats; d0 = done_cnt;
    iss_cnt = 0; hs_cnt = 0; max_out = 0;
    start_pb(32'h80, 32'h88, 2'd2, 3);
    wait_done(120, 16'hB4D2, dc);
    repeat (3) tick();
    check("nloop_beats", beats - b0, 6);
    check("nloop_done_once", done_cnt - d0, 1);
    check("nloop_queue_empty", exp_q.size(), 0);
    check("nloop_no_overflow", (max_out <= FD), 1);
    check("nloop_reads", iss_cnt, 6);

    // Single-word window, N-loop with loop_count 0 plays once.
    build_exp(32'h100, 32'h100, 2'd2, 0);
    check("model_single", exp_q[0], 32);
    b0 = beats;
    start_pb(32'h100, 32'h100, 2'd2, 0);
    wait_done(30, 16'hFFFF, dc);
    repeat (2) tick();
    check("single_beats", beats - b0, 1);
    check("single_queue_empty", exp_q.size(), 0);

    // Configuration errors.
    start_pb(32'h10, 32'h08, 2'd1, 0);
    check("err_order_cfg_err", cfg_err, 1);
    check("err_order_busy", busy, 0);
    build_exp(32'h20, 32'h28, 2'd1, 0);
    start_pb(32'h20, 32'h28, 2'd1, 0);
    check("err_cleared", cfg_err, 0);
    wait_done(30, 16'hFFFF, dc);
    tick();
    check("err_clear_queue_empty", exp_q.size(), 0);
    start_pb(32'h04, 32'h18, 2'd1, 0);
    check("err_align_cfg_err", cfg_err, 1);
    check("err_align_busy", busy, 0);
    start_addr = 32'h00; end_addr = 32'h18; mode = 2'd0;
    start = 1'b1; stop = 1'b1;
    #1;
    check("startstop_no_read", portA_en, 0);
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_cfg_err_kept", cfg_err, 1);
    repeat (4) tick();

    // Reset during a stalled run.
    axis.axis_tready = 1'b0;
    build_exp(32'h00, 32'h18, 2'd0, 0);
    start_pb(32'h00, 32'h18, 2'd0, 0);
    repeat (7) tick();
    check("stall_tvalid", axis.axis_tvalid, 1);
    stab_skip = 1'b1;
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", axis.axis_tvalid, 0);
    check("mid_rst_tdata", axis.axis_tdata, 0);
    check("mid_rst_en", portA_en, 0);
    check("mid_rst_addr", portAcpu_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    exp_q.delete();
    axis.axis_tready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (axis.axis_tvalid) cnt++;
    end
    check("post_rst_no_beat", cnt, 0);
    stab_skip = 1'b0;

    // Recovery after reset.
    build_exp(32'h20, 32'h28, 2'd1, 0);
    b0 = beats;
    start_pb(32'h20, 32'h28, 2'd1, 0);
    wait_done(30, 16'hFFFF, dc);
    repeat (2) tick();
    check("recover_beats", beats - b0, 2);
    check("recover_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dac_bram_playback.md
Name: dac_bram_playback

Overview:
- Parametrised successor to the free-running DAC BRAM streamer.
- Reads a word window [start_addr, end_addr] from a BRAM port and plays it out as AXI-Stream to a DAC channel.
- Full tvalid/tready back-pressure, absorbing the BRAM read latency with an output FIFO.
- Three playback modes: continuous loop, one-shot, N-loop. Controlled by start/stop pulses from the PS register bank.

Parameters:
- DWIDTH, 64, data width in bits; address step is DWIDTH/8 bytes.
- RD_LATENCY, 2, BRAM read latency in cycles, from portA_en/addr to valid portA_cpu_rdata; legal range 1..4.
- FIFO_DEPTH, 8, output FIFO depth in words; must be at least RD_LATENCY+2 and a power of two.
- LOOP_W, 16, width of loop_count.

Ports:
- axis_clk  in  1  single clock for all logic and for the BRAM port.
- axis_rst  in  1  synchronous, active-high reset.
- portA_clk  out  1  equals axis_clk.
- portA_rst  out  1  equals axis_rst.
- portA_en  out  1  BRAM read enable; one read issued per cycle when high.
- portAcpu_addr  out  32  byte address.
- portA_we  out  DWIDTH/8  constant 0.
- portA_cpu_wdata  out  DWIDTH  constant 0.
- portA_cpu_rdata  in  DWIDTH  BRAM read data.
- axis_tdata  out  DWIDTH  stream data.
- axis_tvalid  out  1  stream valid.
- axis_tready  in  1  stream ready.
- start_addr  in  32  first byte address; must be DWIDTH/8-aligned.
- end_addr  in  32  last byte address, inclusive.
- mode  in  2  0=continuous loop, 1=one-shot, 2=N-loop, 3=reserved (treated as one-shot).
- loop_count  in  LOOP_W  number of passes in mode 2; 0 is treated as 1.
- start  in  1  single-cycle pulse; begins playback.
- stop  in  1  single-cycle pulse; aborts playback.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse on normal completion, modes 1/2 only.
- cfg_err  out  1  sticky; set on a rejected start; cleared by the next accepted start or by reset.

Behaviour:
- Reset (axis_rst=1 at a clock edge):
  - State returns to IDLE; FIFO and in-flight pipeline are cleared.
  - All outputs go to 0: portA_en, portAcpu_addr, axis_tdata, axis_tvalid, busy, done, cfg_err.
- Configuration latching:
  - start_addr, end_addr, mode and loop_count are latched only on an accepted start; they are ignored while busy.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - A start is accepted if end_addr >= start_addr and both are aligned. It latches the configuration, sets busy and moves to RUN.
  - Otherwise start sets cfg_err and the block stays in IDLE.
- RUN, read issue:
  - Issue condition: fifo_count + inflight < FIFO_DEPTH, where inflight counts valid bits in a RD_LATENCY-deep shift register.
  - When the condition holds, portA_en=1 and portAcpu_addr = the current pointer, with the pointer advancing by DWIDTH/8.
  - When it does not hold, portA_en=0 and the pointer holds.
- RUN, wrap: when an issued address equals the latched end_addr:
  - mode 0: the pointer reloads start_addr.
  - mode 2: the pass counter decrements; the pointer reloads start_addr if passes remain, otherwise the FSM moves to DRAIN.
  - mode 1/3: the FSM moves to DRAIN.
- Single-word window (start_addr == end_addr): the same word repeats according to the mode.
- Read return: portA_cpu_rdata is written into the FIFO exactly RD_LATENCY cycles after its issue cycle, tagged by the shift register.
- AXIS output:
  - axis_tvalid = FIFO not empty; axis_tdata = FIFO head.
  - The FIFO pops on tvalid&tready.
  - Once asserted, tvalid must not drop and tdata must not change until the handshake completes.
- DRAIN:
  - No new reads are issued.
  - When inflight==0 and the FIFO is empty: done=1 for one cycle, busy=0, return to IDLE.
- stop in RUN or DRAIN:
  - Reads stop immediately; the FIFO is flushed; data still in flight is discarded when it returns.
  - After inflight reaches 0 the FSM returns to IDLE with busy=0 and no done pulse.
  - tvalid goes low the cycle after stop, even mid-handshake.
- Simultaneous events:
  - start and stop in the same cycle: stop wins; start is ignored.
  - start while busy: ignored, and cfg_err is unchanged.
- Latency: the first axis_tvalid rises RD_LATENCY+1 cycles after the start-acceptance cycle.
- Throughput: with tready held high, one word per cycle is sustained.
- Arithmetic: addresses are unsigned 32-bit; the pointer never exceeds end_addr, so there is no 32-bit overflow.

Decomposition:
- Package dac_playback_pkg holds:
  - the mode encodings: MODE_LOOP, MODE_ONESHOT, MODE_NLOOP;
  - the FSM state enum;
  - the function bytes_per_word(DWIDTH).
- One sub-module, playback_fifo: a synchronous FIFO with parameters DWIDTH and FIFO_DEPTH. Ports: push, pop, flush, din, dout, count, empty.
- The issue/credit logic and the FSM stay in the top level.

Test Plan:
- Loop mode, tready=1: start_addr=0x00, end_addr=0x18, mode=0, BRAM word n=n → tdata sequence 0,1,2,3,0,1,… with tvalid continuous; first tvalid at cycle RD_LATENCY+1.
- One-shot: start_addr=0x40, end_addr=0x58, mode=1 → exactly 4 beats (words 8..11); done pulses once after the last handshake; busy falls in the same cycle.
- N-loop with back-pressure: mode=2, loop_count=3, 2-word window, tready toggling 1/0 randomly → 6 beats in order; tdata stable while tvalid&!tready; portA_en never causes FIFO overflow.
- Stop mid-run: stop asserted 5 cycles into loop playback → tvalid low the next cycle; no done; busy falls within RD_LATENCY+1 cycles; a new start replays from start_addr.
- Config errors: end_addr=0x08 with start_addr=0x10 → cfg_err=1, busy stays 0; a later valid start clears cfg_err. start+stop in the same cycle → stays IDLE.
- Reset mid-operation: axis_rst asserted during RUN with tready=0 → next cycle all outputs are 0, FIFO is empty, and no stale beat appears after release.
